// File: rtl/frame_store_pkg.sv
// Shared types for the frame store: FSM state encoding and pixel-index width helper.
package frame_store_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, FILTER, DRAIN} fsState_t;

  function automatic int pixIdxW(input int imgW, input int imgH);
    return (imgW * imgH > 1) ? $clog2(imgW * imgH) : 1;
  endfunction

endpackage

// File: rtl/frame_store_bitmem.sv
// 1-bit RAM: one synchronous write port, one registered read port that holds when re=0.
module frame_store_bitmem import frame_store_pkg::*; #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= 1'b0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_store_server.sv
// Frame store serving a median filter: host load -> filter start -> filter read/write -> host drain.
// Define FRAME_STORE_OOB_CHECK_EN to range-check filter addresses and report via sticky addrError.
module frame_store_server import frame_store_pkg::*; #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadValid,
  input  logic              loadData,
  output logic              loadReady,
  output logic              filterStart,
  input  logic              filterReady,
  input  logic              filterDone,
  input  logic [ADDR_W-1:0] xAddressIn,
  input  logic [ADDR_W-1:0] yAddressIn,
  output logic              pixelData,
  input  logic [ADDR_W-1:0] xMedianAddress,
  input  logic [ADDR_W-1:0] yMedianAddress,
  input  logic              writeEnable,
  input  logic              medianData,
  output logic              outValid,
  output logic              outData,
  output logic              outLast,
  input  logic              outReady,
  output logic              busy,
  output logic              addrError
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IDX_W = pixIdxW(IMG_W, IMG_H);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  fsState_t         state;
  logic [IDX_W-1:0] loadCnt, drainCnt;
  logic [IDX_W-1:0] rdIdx, wrIdx, resRaddr;
  logic             srcWe, resWe, resRe, srcQ, resQ, wrOk;

  assign rdIdx = IDX_W'(32'(yAddressIn) * IMG_W + 32'(xAddressIn));
  assign wrIdx = IDX_W'(32'(yMedianAddress) * IMG_W + 32'(xMedianAddress));

`ifdef FRAME_STORE_OOB_CHECK_EN
  logic rdInRange, rdOob;

  assign rdInRange = (32'(xAddressIn) < IMG_W) && (32'(yAddressIn) < IMG_H);
  assign wrOk      = (32'(xMedianAddress) < IMG_W) && (32'(yMedianAddress) < IMG_H);

  // rdOob travels with the read so the zeroed pixel lines up with its address
  always_ff @(posedge clk) begin
    if (reset) begin
      rdOob     <= 1'b0;
      addrError <= 1'b0;
    end else if (state == FILTER) begin
      rdOob <= !rdInRange;
      if (!rdInRange || (writeEnable && !wrOk)) addrError <= 1'b1;
    end
  end

  assign pixelData = srcQ & ~rdOob;
`else
  // No reporting, but linear indices past the frame are still kept off the array
  assign wrOk      = (32'(yMedianAddress) * IMG_W + 32'(xMedianAddress)) < NPIX;
  assign addrError = 1'b0;
  assign pixelData = srcQ;
`endif

  assign srcWe   = (state == LOAD) && loadValid && loadReady;
  assign resWe   = (state == FILTER) && writeEnable && wrOk;
  assign outData = resQ;

  // Drain prefetch: fetch beat 0 on entry, then the next beat on each non-final handshake
  always_comb begin
    resRe    = 1'b0;
    resRaddr = drainCnt;
    if (state == DRAIN) begin
      if (!outValid) begin
        resRe = 1'b1;
      end else if (outReady && !outLast) begin
        resRe    = 1'b1;
        resRaddr = drainCnt + 1'b1;
      end
    end
  end

  frame_store_bitmem #(.AW(IDX_W)) srcMem (
    .clk   (clk),
    .reset (reset),
    .we    (srcWe),
    .waddr (loadCnt),
    .wdata (loadData),
    .re    (state == FILTER),
    .raddr (rdIdx),
    .rdata (srcQ)
  );

  frame_store_bitmem #(.AW(IDX_W)) resMem (
    .clk   (clk),
    .reset (reset),
    .we    (resWe),
    .waddr (wrIdx),
    .wdata (medianData),
    .re    (resRe),
    .raddr (resRaddr),
    .rdata (resQ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      loadCnt     <= '0;
      drainCnt    <= '0;
      loadReady   <= 1'b0;
      filterStart <= 1'b0;
      outValid    <= 1'b0;
      outLast     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      filterStart <= 1'b0;
      unique case (state)
        IDLE: if (loadValid) begin
          state     <= LOAD;
          loadReady <= 1'b1;
          loadCnt   <= '0;
          busy      <= 1'b1;
        end
        LOAD: if (loadValid && loadReady) begin
          if (loadCnt == LAST_IDX) begin
            state     <= START;
            loadReady <= 1'b0;
          end else begin
            loadCnt <= loadCnt + 1'b1;
          end
        end
        START: if (filterReady) begin
          filterStart <= 1'b1;
          state       <= FILTER;
        end
        FILTER: if (filterDone) begin
          state    <= DRAIN;
          drainCnt <= '0;
          outValid <= 1'b0;
          outLast  <= 1'b0;
        end
        DRAIN: begin
          if (!outValid) begin
            outValid <= 1'b1;
            outLast  <= (drainCnt == LAST_IDX);
          end else if (outReady) begin
            if (outLast) begin
              state    <= IDLE;
              outValid <= 1'b0;
              outLast  <= 1'b0;
              busy     <= 1'b0;
            end else begin
              drainCnt <= drainCnt + 1'b1;
              outLast  <= (drainCnt + 1'b1 == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
